// File: rtl/imm_gen_pipe_if.sv
// imm_gen_pipe_if: request/response bundle between a producer and the immediate generator
interface imm_gen_pipe_if #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 5,
   parameter int CNT_W = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      instr;
   logic [2:0]       imm_src;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [XLEN-1:0]  imm;
   logic [TAG_W-1:0] out_tag;
   logic             illegal;
   logic [CNT_W-1:0] illegal_cnt;
   modport master (
      output in_valid, instr, imm_src, in_tag, out_ready,
      input  in_ready, out_valid, imm, out_tag, illegal, illegal_cnt
   );
   modport slave (
      input  in_valid, instr, imm_src, in_tag, out_ready,
      output in_ready, out_valid, imm, out_tag, illegal, illegal_cnt
   );
endinterface

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: RISC-V immediate decoder feeding a 2-entry result FIFO with tag and illegal flag
module imm_gen_pipe #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 5,
   parameter int CNT_W = 8
) (
   input logic            clk,
   input logic            reset,
   imm_gen_pipe_if.slave  bus
);
   logic [XLEN-1:0]  imm_q [2];
   logic [XLEN-1:0]  imm_d [2];
   logic [TAG_W-1:0] tag_q [2];
   logic [TAG_W-1:0] tag_d [2];
   logic [1:0]       ill_q, ill_d;
   logic             wp_q, wp_d, rp_q, rp_d;
   logic [1:0]       occ_q, occ_d;
   logic [CNT_W-1:0] icnt_q, icnt_d;
   logic [31:0]      ins, r32;
   logic [2:0]       src;
   logic [XLEN-1:0]  imm_c;
   logic             bad, push, pop;

   assign bus.in_ready    = occ_q < 2'd2;
   assign bus.out_valid   = occ_q != 2'd0;
   assign bus.imm         = bus.out_valid ? imm_q[rp_q] : '0;
   assign bus.out_tag     = bus.out_valid ? tag_q[rp_q] : '0;
   assign bus.illegal     = bus.out_valid & ill_q[rp_q];
   assign bus.illegal_cnt = icnt_q;
   assign push            = bus.in_valid & bus.in_ready;
   assign pop             = bus.out_valid & bus.out_ready;

   // decode the immediate as a 32-bit value, then widen (shamt is the only zero-extended form)
   always_comb begin
      ins   = bus.instr;
      src   = bus.imm_src;
      r32   = src == 3'd0 ? {{20{ins[31]}}, ins[31:20]} :
              src == 3'd1 ? {{20{ins[31]}}, ins[31:25], ins[11:7]} :
              src == 3'd2 ? {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0} :
              src == 3'd3 ? {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0} :
              src == 3'd4 ? {ins[31:12], 12'b0} :
              XLEN == 64  ? {26'b0, ins[25:20]} : {27'b0, ins[24:20]};
      bad   = src[2] & src[1];
      imm_c = bad ? '0 : src == 3'd5 ? XLEN'(r32) : XLEN'($signed(r32));
   end

   // next state: FIFO write, 1-bit pointers, occupancy and saturating illegal count
   always_comb begin
      imm_d = imm_q;
      tag_d = tag_q;
      ill_d = ill_q;
      if (push) begin
         imm_d[wp_q] = imm_c;
         tag_d[wp_q] = bus.in_tag;
         ill_d[wp_q] = bad;
      end
      wp_d   = wp_q ^ push;
      rp_d   = rp_q ^ pop;
      occ_d  = occ_q + 2'(push) - 2'(pop);
      icnt_d = (push && bad && icnt_q != '1) ? icnt_q + CNT_W'(1) : icnt_q;
   end

   // state registers; reset drops all buffered entries and blocks any transfer at that edge
   always_ff @(posedge clk) begin
      if (reset) begin
         occ_q  <= '0;
         wp_q   <= 1'b0;
         rp_q   <= 1'b0;
         icnt_q <= '0;
      end else begin
         occ_q  <= occ_d;
         wp_q   <= wp_d;
         rp_q   <= rp_d;
         icnt_q <= icnt_d;
         imm_q  <= imm_d;
         tag_q  <= tag_d;
         ill_q  <= ill_d;
      end
   end
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: vector table, corner sequences and random traffic against a queue-based model
module tb_imm_gen_pipe;
   logic        clk = 1'b0;
   logic        reset;
   logic        iv, ordy;
   logic [31:0] ins;
   logic [2:0]  src;
   logic [4:0]  tg;
   int          checks = 0, errors = 0;

   typedef struct { logic [31:0] w; logic [2:0] s; logic [4:0] t; } ent_t;
   typedef struct { logic [31:0] w; logic [2:0] s; logic [63:0] e32; logic [63:0] e64; } vec_t;
   ent_t q[$];
   vec_t vt[8];
   int   c32, c64;
   logic [4:0] seen[$];

   imm_gen_pipe_if #(.XLEN(32), .TAG_W(5), .CNT_W(4)) b32 ();
   imm_gen_pipe_if #(.XLEN(64), .TAG_W(5), .CNT_W(8)) b64 ();

   assign b32.in_valid = iv;   assign b64.in_valid = iv;
   assign b32.instr = ins;     assign b64.instr = ins;
   assign b32.imm_src = src;   assign b64.imm_src = src;
   assign b32.in_tag = tg;     assign b64.in_tag = tg;
   assign b32.out_ready = ordy; assign b64.out_ready = ordy;

   imm_gen_pipe #(.XLEN(32), .TAG_W(5), .CNT_W(4)) d32 (.clk(clk), .reset(reset), .bus(b32));
   imm_gen_pipe #(.XLEN(64), .TAG_W(5), .CNT_W(8)) d64 (.clk(clk), .reset(reset), .bus(b64));

   always #5 clk = ~clk;

   function automatic logic [63:0] ref_imm(logic [31:0] w, logic [2:0] s, bit x64);
      longint sw = longint'($signed(w));
      longint v;
      case (s)
         3'd0: v = sw >>> 20;
         3'd1: v = (sw >>> 25) * 32 + longint'(w[11:7]);
         3'd2: v = (w[31] ? -64'sd4096 : 64'sd0) + longint'(w[7]) * 2048 + longint'(w[30:25]) * 32 + longint'(w[11:8]) * 2;
         3'd3: v = (w[31] ? -64'sd1048576 : 64'sd0) + longint'(w[19:12]) * 4096 + longint'(w[20]) * 2048 + longint'(w[30:21]) * 2;
         3'd4: v = sw - longint'(w[11:0]);
         3'd5: v = x64 ? longint'(w[25:20]) : longint'(w[24:20]);
         default: v = 0;
      endcase
      return v;
   endfunction

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // compare both DUTs with the model, then advance the model and the clock by one cycle
   task automatic tick();
      bit         v = q.size() != 0;
      logic [63:0] e32 = 0, e64 = 0, r;
      logic [4:0] et = 0;
      bit         eill = 0;
      bit         push, pop;
      if (v) begin
         r = ref_imm(q[0].w, q[0].s, 1'b0);
         e32 = {32'b0, r[31:0]};
         e64 = ref_imm(q[0].w, q[0].s, 1'b1);
         et = q[0].t;
         eill = q[0].s[2] & q[0].s[1];
      end
      chk("rdy32", b32.in_ready, q.size() < 2);
      chk("rdy64", b64.in_ready, q.size() < 2);
      chk("vld32", b32.out_valid, v);
      chk("vld64", b64.out_valid, v);
      chk("imm32", b32.imm, e32);
      chk("imm64", b64.imm, e64);
      chk("tag32", b32.out_tag, et);
      chk("tag64", b64.out_tag, et);
      chk("ill32", b32.illegal, eill);
      chk("ill64", b64.illegal, eill);
      chk("cnt32", b32.illegal_cnt, c32);
      chk("cnt64", b64.illegal_cnt, c64);
      if (reset) begin
         q.delete();
         c32 = 0;
         c64 = 0;
      end else begin
         pop  = v && ordy;
         push = q.size() < 2 && iv;
         if (pop) begin
            seen.push_back(q[0].t);
            void'(q.pop_front());
         end
         if (push) begin
            q.push_back('{ins, src, tg});
            if (src[2] & src[1]) begin
               c32 = c32 < 15 ? c32 + 1 : c32;
               c64 = c64 < 255 ? c64 + 1 : c64;
            end
         end
      end
      @(negedge clk);
   endtask

   initial begin
      vt[0] = '{32'hFFF00093, 3'd0, 64'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF};
      vt[1] = '{32'hFE512E23, 3'd1, 64'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC};
      vt[2] = '{32'hFE000CE3, 3'd2, 64'hFFFFFFF8, 64'hFFFFFFFFFFFFFFF8};
      vt[3] = '{32'hFFDFF06F, 3'd3, 64'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC};
      vt[4] = '{32'h123450B7, 3'd4, 64'h12345000, 64'h0000000012345000};
      vt[5] = '{32'h800000B7, 3'd4, 64'h80000000, 64'hFFFFFFFF80000000};
      vt[6] = '{32'h03F09093, 3'd5, 64'h0000001F, 64'h000000000000003F};
      vt[7] = '{32'h12345678, 3'd6, 64'h0, 64'h0};
      reset = 1'b1; iv = 1'b0; ordy = 1'b1; ins = '0; src = '0; tg = '0;
      c32 = 0; c64 = 0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      chk("post_reset_ready", b32.in_ready, 1'b1);
      chk("post_reset_imm", b64.imm, 64'h0);
      tick();
      // table-driven format vectors, result expected one cycle after acceptance
      for (int i = 0; i < 8; i++) begin
         iv = 1'b1; ins = vt[i].w; src = vt[i].s; tg = 5'(i + 3);
         tick();
         iv = 1'b0;
         chk("vec_vld", b32.out_valid, 1'b1);
         chk("vec_imm32", b32.imm, vt[i].e32);
         chk("vec_imm64", b64.imm, vt[i].e64);
         chk("vec_tag", b64.out_tag, 5'(i + 3));
         chk("vec_ill", b32.illegal, vt[i].s[2] & vt[i].s[1]);
         tick();
      end
      // backpressure: three requests with the consumer stalled, then drain
      ordy = 1'b0; iv = 1'b1; src = 3'd0;
      for (int t = 1; t <= 3; t++) begin
         tg = 5'(t); ins = $urandom;
         if (t == 3) chk("bp_full_ready", b32.in_ready, 1'b0);
         tick();
      end
      seen.delete();
      ordy = 1'b1;
      tick();
      tick();
      iv = 1'b0;
      repeat (2) tick();
      chk("bp_count", seen.size(), 3);
      for (int k = 0; k < 3 && k < seen.size(); k++) chk("bp_order", seen[k], 5'(k + 1));
      // illegal requests: 32-bit instance counter saturates at 15
      iv = 1'b1; src = 3'd6;
      for (int k = 0; k < 20; k++) begin
         ins = $urandom; tg = 5'(k); src = (k % 2 == 0) ? 3'd6 : 3'd7;
         tick();
      end
      iv = 1'b0;
      tick();
      chk("ill_sat32", b32.illegal_cnt, 4'd15);
      chk("ill_cnt64", b64.illegal_cnt, 8'd21);
      // reset with two entries buffered
      ordy = 1'b0; iv = 1'b1; src = 3'd4;
      repeat (2) begin ins = $urandom; tg = 5'($urandom); tick(); end
      reset = 1'b1;
      tick();
      reset = 1'b0; iv = 1'b0;
      chk("rst_vld", b32.out_valid, 1'b0);
      chk("rst_imm", b64.imm, 64'h0);
      chk("rst_tag", b32.out_tag, 5'h0);
      chk("rst_rdy", b64.in_ready, 1'b1);
      chk("rst_cnt", b32.illegal_cnt, 4'h0);
      tick();
      // streaming: one result per cycle once the pipe is primed
      iv = 1'b1; ordy = 1'b1;
      for (int k = 0; k < 100; k++) begin
         ins = $urandom; src = 3'($urandom_range(0, 7)); tg = 5'($urandom);
         if (k > 0) chk("stream_vld", b32.out_valid, 1'b1);
         tick();
      end
      // random handshakes on both sides
      for (int k = 0; k < 300; k++) begin
         iv = 1'($urandom); ordy = 1'($urandom);
         ins = $urandom; src = 3'($urandom_range(0, 7)); tg = 5'($urandom);
         tick();
      end
      iv = 1'b0; ordy = 1'b1;
      repeat (3) tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
